// File: rtl/stopwatch_bcd.sv
// MM:SS BCD stopwatch with synchronised tick/start-stop inputs.
// Ports: sysclk, reset, tick_in, start_stop, clear -> BCD digits, running, wrap.
module stopwatch_bcd #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       tick_in,
  input  logic       start_stop,
  input  logic       clear,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic       running,
  output logic       wrap
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_e;

  logic [SYNC_STAGES-1:0] tick_sync_q;
  logic [SYNC_STAGES-1:0] ss_sync_q;
  logic                   tick_prev_q;
  logic                   ss_prev_q;
  logic                   tick_pulse;
  logic                   ss_pulse;

  state_e     state_q, state_d;
  logic [3:0] so_q, so_d;
  logic [3:0] st_q, st_d;
  logic [3:0] mo_q, mo_d;
  logic [3:0] mt_q, mt_d;
  logic       wrap_q, wrap_d;
  logic       running_q;
  logic       count_en;

  always_ff @(posedge sysclk) begin
    if (reset) begin
      tick_sync_q <= '0;
      ss_sync_q   <= '0;
      tick_prev_q <= 1'b0;
      ss_prev_q   <= 1'b0;
    end else begin
      tick_sync_q <= {tick_sync_q[SYNC_STAGES-2:0], tick_in};
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], start_stop};
      tick_prev_q <= tick_sync_q[SYNC_STAGES-1];
      ss_prev_q   <= ss_sync_q[SYNC_STAGES-1];
    end
  end

  assign tick_pulse = tick_sync_q[SYNC_STAGES-1] & ~tick_prev_q;
  assign ss_pulse   = ss_sync_q[SYNC_STAGES-1] & ~ss_prev_q;

  // Counting uses the state before this edge's transition, so a
  // coincident stop still counts and a coincident start does not.
  assign count_en = tick_pulse && (state_q == RUN);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (ss_pulse) state_d = RUN;
      PAUSE:   if (ss_pulse) state_d = RUN;
      RUN:     if (ss_pulse) state_d = PAUSE;
      default: state_d = IDLE;
    endcase
    if (clear) state_d = IDLE;
  end

  always_comb begin
    so_d   = so_q;
    st_d   = st_q;
    mo_d   = mo_q;
    mt_d   = mt_q;
    wrap_d = 1'b0;
    if (count_en) begin
      if (so_q == 4'd9) begin
        so_d = 4'd0;
        if (st_q == 4'd5) begin
          st_d = 4'd0;
          if (mo_q == 4'd9) begin
            mo_d = 4'd0;
            if (mt_q == 4'd5) begin
              mt_d   = 4'd0;
              wrap_d = 1'b1;
            end else begin
              mt_d = mt_q + 4'd1;
            end
          end else begin
            mo_d = mo_q + 4'd1;
          end
        end else begin
          st_d = st_q + 4'd1;
        end
      end else begin
        so_d = so_q + 4'd1;
      end
    end
    if (clear) begin
      so_d   = 4'd0;
      st_d   = 4'd0;
      mo_d   = 4'd0;
      mt_d   = 4'd0;
      wrap_d = 1'b0;
    end
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q   <= IDLE;
      so_q      <= 4'd0;
      st_q      <= 4'd0;
      mo_q      <= 4'd0;
      mt_q      <= 4'd0;
      wrap_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      so_q      <= so_d;
      st_q      <= st_d;
      mo_q      <= mo_d;
      mt_q      <= mt_d;
      wrap_q    <= wrap_d;
      running_q <= (state_d == RUN);
    end
  end

  assign sec_ones = so_q;
  assign sec_tens = st_q;
  assign min_ones = mo_q;
  assign min_tens = mt_q;
  assign running  = running_q;
  assign wrap     = wrap_q;

endmodule

// File: doc/stopwatch_bcd.md
STOPWATCH_BCD -- requirements
Module: stopwatch_bcd

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchroniser depth for tick_in and start_stop; legal range 2-3.
REQ-002 sysclk  input  1  system clock; all state SHALL update on its rising edge only.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 tick_in  input  1  1 Hz square wave from the upstream clock divider; level, asynchronous to nothing but treated as unsynchronised.
REQ-005 start_stop  input  1  start/pause button level; debounced upstream, unsynchronised.
REQ-006 clear  input  1  synchronous clear of elapsed time, level-sensitive.
REQ-007 sec_ones  output  4  BCD seconds units, 0-9.
REQ-008 sec_tens  output  4  BCD seconds tens, 0-5.
REQ-009 min_ones  output  4  BCD minutes units, 0-9.
REQ-010 min_tens  output  4  BCD minutes tens, 0-5.
REQ-011 running  output  1  high while FSM is in RUN.
REQ-012 wrap  output  1  one-cycle pulse on 59:59 -> 00:00 rollover.

Function
REQ-013 tick_in and start_stop SHALL each pass through a SYNC_STAGES flop chain, then a one-flop rising-edge detector producing single-cycle tick_pulse / ss_pulse.
REQ-014 Latency: with SYNC_STAGES=2, digits SHALL change on the 3rd rising sysclk edge at which tick_in is sampled high after being low.
REQ-015 Exactly one tick_pulse per tick_in rising edge; high level or falling edge SHALL produce nothing.
REQ-016 FSM states: IDLE, RUN, PAUSE.
REQ-017 IDLE -- ss_pulse -> RUN; PAUSE -- ss_pulse -> RUN; RUN -- ss_pulse -> PAUSE.
REQ-018 clear (not in reset) SHALL force all digits to 0 and state to IDLE, from any state.
REQ-019 Digits SHALL advance by one second only on a cycle where tick_pulse=1 and current state is RUN.
REQ-020 BCD carry chain: sec_ones 9->0 carries into sec_tens; sec_tens 5->0 carries into min_ones; min_ones 9->0 carries into min_tens; min_tens 5->0 asserts wrap.
REQ-021 At 59:59 a counted tick SHALL yield 00:00 with wrap=1 in that same cycle the digits show 00:00; wrap=0 all other cycles.
REQ-022 Digit values outside their legal ranges SHALL be unreachable.
REQ-023 tick_pulse and ss_pulse in the same cycle while RUN: increment SHALL occur, state then moves to PAUSE.
REQ-024 tick_pulse and ss_pulse in the same cycle while PAUSE/IDLE: no increment, state moves to RUN.
REQ-025 clear together with tick_pulse or ss_pulse: clear SHALL win; digits 0, state IDLE, wrap=0.
REQ-026 In IDLE and PAUSE digits SHALL hold; ticks are discarded, not queued.
REQ-027 running SHALL be a registered decode of state==RUN, changing on the same edge as the state.

Reset
REQ-028 reset SHALL dominate clear and all pulses.
REQ-029 On reset: state IDLE; all digits 0; running 0; wrap 0; synchroniser and edge-detector flops 0.
REQ-030 A tick_in already high when reset deasserts SHALL produce one tick_pulse (edge flop cleared to 0); not counted since state is IDLE.
REQ-031 Reset asserted mid-count SHALL take effect on the next rising edge, no partial carry retained.

Verification
REQ-032 Reset, pulse start_stop, apply 5 tick_in rising edges -> digits 00:05, running=1, exactly 5 increments.
REQ-033 Preload via 3599 counted ticks (59:59), one more tick -> 00:00 with wrap high exactly one cycle.
REQ-034 RUN at 00:09, ss_pulse coincident with tick_pulse -> 00:10, state PAUSE, running=0; further ticks leave 00:10.
REQ-035 RUN at 12:34, assert clear coincident with tick_pulse -> 00:00, IDLE, running=0, wrap=0.
REQ-036 tick_in held high 100 cycles then low 100 cycles while RUN -> exactly one increment; change lands 3 edges after first high sample.
REQ-037 Assert reset at 07:59 during a carry cycle -> next edge shows 00:00, IDLE, all outputs 0.
